y86_stage_sequencer: RTL and testbench
======================================

Name: y86_stage_sequencer

Overview:
Multi-cycle control sequencer for the Y86-64 core. It owns the PC register and steps the existing fetch, decode, execute, memory and write_back datapath stages through one stage per clock. It handles the data-memory req/ack handshake with timeout, Y86 status codes and halting, a single-step debug mode, and saturating instruction and cycle counters. It sits in the y86 top level between the stage modules and the memory interface.

Parameters:
ADDR_W, 64, PC width in bits.
PC_RESET, 0, PC value loaded on reset.
MEM_TIMEOUT, 16, max MEMORY-state cycles without dmem_ack before an ADR fault; must be >=1.
CNT_W, 32, width of instr_count and cycle_count.

Ports:
clk  in  1  clock, rising edge.
rst_n  in  1  reset, asynchronous, active-low.
run  in  1  level; free-run enable.
step_mode  in  1  level; 1 = pause after every instruction.
step_go  in  1  single-cycle pulse; starts one instruction while paused in step mode.
icode_in  in  4  icode from fetch, valid in FETCH.
instr_valid  in  1  fetch decoded a legal icode/ifun.
imem_err  in  1  fetch address out of range.
dmem_ack  in  1  data memory completed access.
dmem_err  in  1  data memory address error, qualified by dmem_ack.
next_pc_in  in  ADDR_W  new PC from PC-select logic.
pc  out  ADDR_W  current PC.
fetch_en, decode_en, execute_en, memory_en, wb_en, pc_en  out  1 each  stage strobes.
dmem_req  out  1  data memory request.
stat  out  3  Y86 status: AOK=1, HLT=2, ADR=3, INS=4.
halted  out  1  in HALT state.
instr_count  out  CNT_W  retired instructions, saturating.
cycle_count  out  CNT_W  active cycles, saturating.

Behaviour:
- Reset (asynchronous, rst_n=0): state IDLE, pc=PC_RESET, stat=AOK, all strobes 0, dmem_req 0, halted 0, counters 0, timeout counter 0. Reset also applies mid-instruction; dmem_req drops with no clock edge.
- States: IDLE, FETCH, DECODE, EXECUTE, MEMORY, WRITEBACK, PCUPD, HALT. All outputs are Moore, decoded from registered state and registers only.
- IDLE -> FETCH when (step_mode=0 and run=1) or (step_mode=1 and step_go=1). Otherwise IDLE holds.
- FETCH: fetch_en=1. Checks in priority order:
  - imem_err -> stat=ADR, HALT.
  - !instr_valid -> stat=INS, HALT.
  - icode_in=0 (halt) -> stat=HLT, HALT.
  - Otherwise -> DECODE.
- DECODE (decode_en) -> EXECUTE (execute_en) -> MEMORY, one cycle each.
- MEMORY: memory_en=1. The memory-op flag is latched in FETCH from icode. Memory ops are rmmovq 4, mrmovq 5, call 8, ret 9, pushq A, popq B.
  - Non-mem op: 1 cycle, dmem_req=0, -> WRITEBACK.
  - Mem op: dmem_req=1 from the first MEMORY cycle until the edge that samples dmem_ack=1. The timeout counter increments each MEMORY cycle.
  - dmem_ack=1 and dmem_err=0 -> WRITEBACK.
  - dmem_ack=1 and dmem_err=1 -> stat=ADR, HALT.
  - No ack after MEM_TIMEOUT cycles -> stat=ADR, HALT.
  - If ack and timeout fall in the same cycle, ack wins.
  - dmem_ack outside MEMORY is ignored.
- WRITEBACK: wb_en=1, -> PCUPD.
- PCUPD: pc_en=1; pc<=next_pc_in; instr_count+1 (saturating).
  - Next state FETCH if step_mode=0 and run=1, otherwise IDLE.
  - Dropping run mid-instruction finishes the instruction first.
- HALT: all strobes 0, dmem_req 0, halted=1. pc and stat are frozen. Exit only via reset.
- Faulting or halting instructions do not update pc or instr_count.
- Latency:
  - Non-mem instruction: 6 cycles FETCH..PCUPD.
  - Mem instruction: 5 + N cycles, where N = MEMORY cycles (1 if ack arrives on the first cycle).
- cycle_count increments in every state except IDLE and HALT, saturating at all-ones.
- step_go outside IDLE is ignored. The timeout counter clears on MEMORY entry.

Decomposition:
- Shared include y86_defs.vh holds:
  - icode constants (HALT..POPQ).
  - stat codes AOK/HLT/ADR/INS.
  - the sequencer state encoding.
  - it is reused by the fetch and memory stages.
- One sub-module, y86_sat_counter (parameter W; inputs clk, rst_n, inc; output count), is instantiated twice for the two counters.

Test Plan:
1. Reset, run=1, icode=1 (nop), next_pc_in=0x1:
   - Strobes fetch..pc_en pulse on 6 consecutive cycles.
   - pc=0x1, instr_count=1, cycle_count=6, stat=1.
2. icode=5 (mrmovq), dmem_ack raised on the 3rd MEMORY cycle:
   - dmem_req high exactly 3 cycles.
   - Instruction takes 8 cycles; pc=next_pc_in.
3. MEM_TIMEOUT=4, icode=A (pushq), ack never asserted:
   - After 4 MEMORY cycles: stat=3, halted=1, dmem_req=0.
   - pc and instr_count unchanged.
4. Fetch faults:
   - icode=0 -> stat=2, halted after FETCH, decode_en never pulses.
   - instr_valid=0 -> stat=4.
   - imem_err=1 together with instr_valid=0 -> stat=3 (priority).
5. step_mode=1, three nops:
   - Exactly one instruction retires per step_go pulse.
   - step_go pulsed during EXECUTE is ignored; instr_count=3 after three IDLE pulses.
6. rst_n low mid-MEMORY with dmem_req=1:
   - dmem_req=0 before the next clk edge.
   - pc=PC_RESET, counters 0, stat=1, state IDLE.

Source files
------------

// File: rtl/y86_stage_sequencer_pkg.sv
// Shared Y86-64 definitions: icodes, status codes, sequencer state encoding.
package y86_stage_sequencer_pkg;

    localparam logic [3:0] IHalt   = 4'h0;
    localparam logic [3:0] INop    = 4'h1;
    localparam logic [3:0] IRrmovq = 4'h2;
    localparam logic [3:0] IIrmovq = 4'h3;
    localparam logic [3:0] IRmmovq = 4'h4;
    localparam logic [3:0] IMrmovq = 4'h5;
    localparam logic [3:0] IOpq    = 4'h6;
    localparam logic [3:0] IJxx    = 4'h7;
    localparam logic [3:0] ICall   = 4'h8;
    localparam logic [3:0] IRet    = 4'h9;
    localparam logic [3:0] IPushq  = 4'hA;
    localparam logic [3:0] IPopq   = 4'hB;

    typedef enum logic [2:0] {
        StatAok = 3'd1,
        StatHlt = 3'd2,
        StatAdr = 3'd3,
        StatIns = 3'd4
    } stat_e;

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StDecode,
        StExecute,
        StMemory,
        StWriteback,
        StPcUpd,
        StHalt
    } state_e;

    // Instructions that need a data-memory transaction in the MEMORY stage.
    function automatic logic is_mem_op(logic [3:0] icode);
        return icode inside {IRmmovq, IMrmovq, ICall, IRet, IPushq, IPopq};
    endfunction

endpackage

// File: rtl/y86_stage_sequencer_if.sv
// Bundle between the sequencer (master) and the stage/memory side (slave).
interface y86_stage_sequencer_if #(
    parameter int unsigned ADDR_W = 64,
    parameter int unsigned CNT_W  = 32
);
    logic              run;
    logic              step_mode;
    logic              step_go;
    logic [3:0]        icode_in;
    logic              instr_valid;
    logic              imem_err;
    logic              dmem_ack;
    logic              dmem_err;
    logic [ADDR_W-1:0] next_pc_in;
    logic [ADDR_W-1:0] pc;
    logic              fetch_en;
    logic              decode_en;
    logic              execute_en;
    logic              memory_en;
    logic              wb_en;
    logic              pc_en;
    logic              dmem_req;
    logic [2:0]        stat;
    logic              halted;
    logic [CNT_W-1:0]  instr_count;
    logic [CNT_W-1:0]  cycle_count;

    modport master (
        input  run, step_mode, step_go, icode_in, instr_valid, imem_err,
               dmem_ack, dmem_err, next_pc_in,
        output pc, fetch_en, decode_en, execute_en, memory_en, wb_en, pc_en,
               dmem_req, stat, halted, instr_count, cycle_count
    );

    modport slave (
        output run, step_mode, step_go, icode_in, instr_valid, imem_err,
               dmem_ack, dmem_err, next_pc_in,
        input  pc, fetch_en, decode_en, execute_en, memory_en, wb_en, pc_en,
               dmem_req, stat, halted, instr_count, cycle_count
    );

endinterface

// File: rtl/y86_sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
module y86_sat_counter #(
    parameter int unsigned W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] count_q;

    // Increment on request unless already saturated.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (inc && (count_q != '1)) begin
            count_q <= count_q + W'(1);
        end
    end

    assign count = count_q;

endmodule

// File: rtl/y86_stage_sequencer.sv
// Multi-cycle Y86-64 control sequencer: owns the PC, steps the datapath stages
// one per clock, runs the data-memory handshake with timeout, tracks status.
module y86_stage_sequencer
    import y86_stage_sequencer_pkg::*;
#(
    parameter int unsigned       ADDR_W      = 64,
    parameter logic [ADDR_W-1:0] PC_RESET    = '0,
    parameter int unsigned       MEM_TIMEOUT = 16,
    parameter int unsigned       CNT_W       = 32
) (
    input logic                   clk,
    input logic                   rst_n,
    y86_stage_sequencer_if.master bus
);

    // tmo_q holds (MEMORY cycles already spent); the last allowed cycle is MEM_TIMEOUT-1.
    localparam int unsigned   TmoW    = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT);
    localparam logic [TmoW-1:0] TmoLast = TmoW'(MEM_TIMEOUT - 1);

    state_e            state_q, state_d;
    stat_e             stat_q, stat_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              mem_op_q, mem_op_d;
    logic [TmoW-1:0]   tmo_q, tmo_d;

    logic fetch_en_q, decode_en_q, execute_en_q, memory_en_q, wb_en_q, pc_en_q;
    logic dmem_req_q, halted_q;

    logic start;
    assign start = (!bus.step_mode && bus.run) || (bus.step_mode && bus.step_go);

    // Next-state, status, PC and timeout logic.
    always_comb begin
        state_d  = state_q;
        stat_d   = stat_q;
        pc_d     = pc_q;
        mem_op_d = mem_op_q;
        tmo_d    = tmo_q;
        case (state_q)
            StIdle: begin
                if (start) state_d = StFetch;
            end
            StFetch: begin
                mem_op_d = is_mem_op(bus.icode_in);
                if (bus.imem_err) begin
                    stat_d  = StatAdr;
                    state_d = StHalt;
                end else if (!bus.instr_valid) begin
                    stat_d  = StatIns;
                    state_d = StHalt;
                end else if (bus.icode_in == IHalt) begin
                    stat_d  = StatHlt;
                    state_d = StHalt;
                end else begin
                    state_d = StDecode;
                end
            end
            StDecode:  state_d = StExecute;
            StExecute: begin
                state_d = StMemory;
                tmo_d   = '0;
            end
            StMemory: begin
                if (!mem_op_q) begin
                    state_d = StWriteback;
                end else if (bus.dmem_ack) begin
                    // Ack is checked before timeout so a last-cycle ack still completes.
                    if (bus.dmem_err) begin
                        stat_d  = StatAdr;
                        state_d = StHalt;
                    end else begin
                        state_d = StWriteback;
                    end
                end else if (tmo_q == TmoLast) begin
                    stat_d  = StatAdr;
                    state_d = StHalt;
                end else begin
                    tmo_d = tmo_q + TmoW'(1);
                end
            end
            StWriteback: state_d = StPcUpd;
            StPcUpd: begin
                pc_d    = bus.next_pc_in;
                state_d = (!bus.step_mode && bus.run) ? StFetch : StIdle;
            end
            StHalt:  state_d = StHalt;
            default: state_d = StIdle;
        endcase
    end

    // State registers; strobes are registered from the next state so they align with state_q.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            stat_q       <= StatAok;
            pc_q         <= PC_RESET;
            mem_op_q     <= 1'b0;
            tmo_q        <= '0;
            fetch_en_q   <= 1'b0;
            decode_en_q  <= 1'b0;
            execute_en_q <= 1'b0;
            memory_en_q  <= 1'b0;
            wb_en_q      <= 1'b0;
            pc_en_q      <= 1'b0;
            dmem_req_q   <= 1'b0;
            halted_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            stat_q       <= stat_d;
            pc_q         <= pc_d;
            mem_op_q     <= mem_op_d;
            tmo_q        <= tmo_d;
            fetch_en_q   <= (state_d == StFetch);
            decode_en_q  <= (state_d == StDecode);
            execute_en_q <= (state_d == StExecute);
            memory_en_q  <= (state_d == StMemory);
            wb_en_q      <= (state_d == StWriteback);
            pc_en_q      <= (state_d == StPcUpd);
            dmem_req_q   <= (state_d == StMemory) && mem_op_d;
            halted_q     <= (state_d == StHalt);
        end
    end

    logic [CNT_W-1:0] instr_cnt, cycle_cnt;

    y86_sat_counter #(.W(CNT_W)) u_instr_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (state_q == StPcUpd),
        .count (instr_cnt)
    );

    y86_sat_counter #(.W(CNT_W)) u_cycle_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   ((state_q != StIdle) && (state_q != StHalt)),
        .count (cycle_cnt)
    );

    assign bus.pc          = pc_q;
    assign bus.fetch_en    = fetch_en_q;
    assign bus.decode_en   = decode_en_q;
    assign bus.execute_en  = execute_en_q;
    assign bus.memory_en   = memory_en_q;
    assign bus.wb_en       = wb_en_q;
    assign bus.pc_en       = pc_en_q;
    assign bus.dmem_req    = dmem_req_q;
    assign bus.stat        = stat_q;
    assign bus.halted      = halted_q;
    assign bus.instr_count = instr_cnt;
    assign bus.cycle_count = cycle_cnt;

endmodule

// File: tb/tb_y86_stage_sequencer.sv
// Self-checking bench: hand-filled vector table, multi-cycle corner sequences,
// and random instructions checked against an instruction-level model.
module tb_y86_stage_sequencer;

    localparam int unsigned AW     = 64;
    localparam int unsigned TMO    = 4;
    localparam int unsigned CW     = 8;
    localparam int          CntMax = (1 << CW) - 1;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    y86_stage_sequencer_if #(.ADDR_W(AW), .CNT_W(CW)) bus ();

    y86_stage_sequencer #(
        .ADDR_W      (AW),
        .PC_RESET    (64'h0),
        .MEM_TIMEOUT (TMO),
        .CNT_W       (CW)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [3:0]  icode;
        bit          valid;
        bit          ierr;
        int          ack_at;   // MEMORY cycle (1-based) that sees ack; 0 = never
        bit          derr;
        logic [63:0] npc;
        int          exp_lat;
        int          exp_stat;
        int          exp_req;
    } vec_t;

    int vectors     = 0;
    int miscompares = 0;

    // Instruction-level model state.
    logic [63:0] m_pc;
    int          m_icount;
    int          m_ccount;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic int sat(input int v);
        return (v > CntMax) ? CntMax : v;
    endfunction

    function automatic bit is_mem(input logic [3:0] ic);
        return ic inside {4'h4, 4'h5, 4'h8, 4'h9, 4'hA, 4'hB};
    endfunction

    // Expected latency, final status and request cycles for one instruction.
    function automatic vec_t predict(input vec_t v);
        vec_t r = v;
        r.exp_req = 0;
        if (v.ierr)               begin r.exp_stat = 3; r.exp_lat = 1; end
        else if (!v.valid)        begin r.exp_stat = 4; r.exp_lat = 1; end
        else if (v.icode == 4'h0) begin r.exp_stat = 2; r.exp_lat = 1; end
        else if (!is_mem(v.icode)) begin r.exp_stat = 1; r.exp_lat = 6; end
        else if (v.ack_at >= 1 && v.ack_at <= TMO) begin
            r.exp_req  = v.ack_at;
            r.exp_stat = v.derr ? 3 : 1;
            r.exp_lat  = v.derr ? 3 + v.ack_at : 5 + v.ack_at;
        end else begin
            r.exp_req  = TMO;
            r.exp_stat = 3;
            r.exp_lat  = 3 + TMO;
        end
        return r;
    endfunction

    function automatic vec_t mk(input logic [3:0] ic, input bit valid, input bit ierr,
                                input int ack_at, input bit derr, input logic [63:0] npc,
                                input int lat, input int stat, input int req);
        vec_t v;
        v.icode = ic; v.valid = valid; v.ierr = ierr; v.ack_at = ack_at; v.derr = derr;
        v.npc = npc; v.exp_lat = lat; v.exp_stat = stat; v.exp_req = req;
        return v;
    endfunction

    function automatic logic [5:0] strobes();
        return {bus.fetch_en, bus.decode_en, bus.execute_en, bus.memory_en, bus.wb_en, bus.pc_en};
    endfunction

    function automatic logic [5:0] exp_strobe(input int idx, input int lat, input bit retire);
        if (idx == 0) return 6'b100000;
        if (idx == 1) return 6'b010000;
        if (idx == 2) return 6'b001000;
        if (retire && idx == lat - 1) return 6'b000001;
        if (retire && idx == lat - 2) return 6'b000010;
        return 6'b000100;
    endfunction

    task automatic idle_inputs();
        bus.run = 1'b0; bus.step_mode = 1'b0; bus.step_go = 1'b0;
        bus.icode_in = 4'h1; bus.instr_valid = 1'b1; bus.imem_err = 1'b0;
        bus.dmem_ack = 1'b0; bus.dmem_err = 1'b0; bus.next_pc_in = '0;
    endtask

    // Enter and leave at a falling edge.
    task automatic do_reset(input bit check_state);
        @(negedge clk);
        rst_n = 1'b0;
        idle_inputs();
        repeat (2) @(negedge clk);
        if (check_state) begin
            check("rst_pc", bus.pc, 64'h0);
            check("rst_stat", 64'(bus.stat), 64'd1);
            check("rst_halted", 64'(bus.halted), 64'd0);
            check("rst_strobes", 64'({strobes(), bus.dmem_req}), 64'd0);
            check("rst_icount", 64'(bus.instr_count), 64'd0);
            check("rst_ccount", 64'(bus.cycle_count), 64'd0);
        end
        rst_n    = 1'b1;
        m_pc     = '0;
        m_icount = 0;
        m_ccount = 0;
    endtask

    // Launch one instruction from IDLE with run pulsed, follow it to IDLE or HALT.
    task automatic run_instr(input vec_t v, input string tag);
        int  active = 0, reqs = 0, decs = 0, mcnt = 0, bad_seq = 0;
        bit  done   = 0;
        bit  retire = (v.exp_stat == 1);
        bus.icode_in = v.icode; bus.instr_valid = v.valid; bus.imem_err = v.ierr;
        bus.next_pc_in = v.npc; bus.dmem_ack = 1'b0; bus.dmem_err = 1'b0;
        bus.step_mode = 1'b0; bus.run = 1'b1;
        for (int c = 0; c < 40 && !done; c++) begin
            @(negedge clk);
            bus.run = 1'b0;
            if (bus.halted || strobes() == 6'b0) begin
                done = 1;
            end else begin
                if (strobes() != exp_strobe(active, v.exp_lat, retire)) bad_seq++;
                active++;
                if (bus.dmem_req)  reqs++;
                if (bus.decode_en) decs++;
                if (bus.memory_en && is_mem(v.icode)) begin
                    mcnt++;
                    bus.dmem_ack = (mcnt == v.ack_at);
                    bus.dmem_err = bus.dmem_ack ? v.derr : 1'($urandom);
                end else begin
                    // Acks outside a memory transaction must be ignored.
                    {bus.dmem_ack, bus.dmem_err} = 2'($urandom);
                end
            end
        end
        bus.dmem_ack = 1'b0;
        if (!done) begin
            vectors++;
            miscompares++;
            $display("FAIL %s_bound: instruction still active after 40 cycles", tag);
        end
        check({tag, "_latency"}, 64'(active), 64'(v.exp_lat));
        check({tag, "_req_cycles"}, 64'(reqs), 64'(v.exp_req));
        check({tag, "_strobe_seq_errs"}, 64'(bad_seq), 64'd0);
        check({tag, "_decode_pulses"}, 64'(decs), (v.exp_lat > 1) ? 64'd1 : 64'd0);
        check({tag, "_stat"}, 64'(bus.stat), 64'(v.exp_stat));
        check({tag, "_halted"}, 64'(bus.halted), 64'(!retire));
        check({tag, "_req_end"}, 64'(bus.dmem_req), 64'd0);
        m_ccount = sat(m_ccount + v.exp_lat);
        if (retire) begin
            m_pc     = v.npc;
            m_icount = sat(m_icount + 1);
        end
        check({tag, "_pc"}, bus.pc, m_pc);
        check({tag, "_icount"}, 64'(bus.instr_count), 64'(m_icount));
        check({tag, "_ccount"}, 64'(bus.cycle_count), 64'(m_ccount));
        if (!retire) begin
            // HALT is sticky and frozen until reset.
            bus.run = 1'b1;
            repeat (3) @(negedge clk);
            bus.run = 1'b0;
            check({tag, "_halt_frozen"},
                  {bus.pc[55:0], 1'b0, bus.stat, 3'b0, bus.halted},
                  {m_pc[55:0], 1'b0, 3'(v.exp_stat), 3'b0, 1'b1});
            check({tag, "_halt_ccount"}, 64'(bus.cycle_count), 64'(m_ccount));
            do_reset(1'b0);
        end
    endtask

    vec_t tbl[11];

    initial begin
        tbl[0]  = mk(4'h1, 1, 0, 0, 0, 64'h1,    6, 1, 0);  // nop
        tbl[1]  = mk(4'h5, 1, 0, 3, 0, 64'h40,   8, 1, 3);  // mrmovq, ack on 3rd cycle
        tbl[2]  = mk(4'h4, 1, 0, 1, 0, 64'h4a,   6, 1, 1);  // rmmovq, immediate ack
        tbl[3]  = mk(4'h8, 1, 0, 4, 0, 64'h100,  9, 1, 4);  // call, ack on timeout cycle
        tbl[4]  = mk(4'h3, 1, 0, 0, 0, 64'h10a,  6, 1, 0);  // irmovq
        tbl[5]  = mk(4'h9, 1, 0, 2, 1, 64'h200,  5, 3, 2);  // ret, dmem_err
        tbl[6]  = mk(4'hA, 1, 0, 0, 0, 64'h300,  7, 3, 4);  // pushq, no ack
        tbl[7]  = mk(4'h0, 1, 0, 0, 0, 64'h400,  1, 2, 0);  // halt
        tbl[8]  = mk(4'h6, 0, 0, 0, 0, 64'h500,  1, 4, 0);  // invalid
        tbl[9]  = mk(4'h6, 0, 1, 0, 0, 64'h600,  1, 3, 0);  // imem_err beats invalid
        tbl[10] = mk(4'hB, 1, 0, 5, 0, 64'h700,  7, 3, 4);  // popq, ack too late

        idle_inputs();
        do_reset(1'b1);

        for (int i = 0; i < 11; i++) run_instr(tbl[i], $sformatf("tbl%0d", i));

        // Single-step: one instruction per step_go, step_go during EXECUTE ignored.
        do_reset(1'b0);
        bus.step_mode = 1'b1;
        bus.run = 1'b1;
        bus.icode_in = 4'h1;
        repeat (3) @(negedge clk);
        check("step_wait_idle", 64'(strobes()), 64'd0);
        for (int k = 0; k < 3; k++) begin
            bus.next_pc_in = 64'(16 * (k + 1));
            bus.step_go = 1'b1;
            @(negedge clk);
            bus.step_go = 1'b0;
            check($sformatf("step%0d_fetch", k), 64'(bus.fetch_en), 64'd1);
            repeat (2) @(negedge clk);
            check($sformatf("step%0d_in_exec", k), 64'(bus.execute_en), 64'd1);
            bus.step_go = 1'b1;
            @(negedge clk);
            bus.step_go = 1'b0;
            repeat (3) @(negedge clk);
            check($sformatf("step%0d_idle", k), 64'(strobes()), 64'd0);
            check($sformatf("step%0d_icount", k), 64'(bus.instr_count), 64'(k + 1));
            repeat (2) @(negedge clk);
            check($sformatf("step%0d_still_idle", k), 64'(strobes()), 64'd0);
        end
        check("step_ccount", 64'(bus.cycle_count), 64'd18);
        check("step_pc", bus.pc, 64'd48);
        bus.step_mode = 1'b0;
        bus.run = 1'b0;

        // Asynchronous reset in the middle of a memory request.
        do_reset(1'b0);
        begin
            bit reached = 0;
            bus.icode_in = 4'h5;
            bus.next_pc_in = 64'hdead;
            bus.run = 1'b1;
            for (int c = 0; c < 10 && !reached; c++) begin
                @(negedge clk);
                bus.run = 1'b0;
                if (bus.memory_en && bus.dmem_req) reached = 1;
            end
            check("midmem_reached", 64'(reached), 64'd1);
            #1 rst_n = 1'b0;
            #1;
            check("midmem_req_drop", 64'(bus.dmem_req), 64'd0);
            check("midmem_strobes", 64'(strobes()), 64'd0);
            check("midmem_pc", bus.pc, 64'h0);
            check("midmem_counts", {48'b0, bus.instr_count, bus.cycle_count}, 64'd0);
            check("midmem_stat", 64'(bus.stat), 64'd1);
            @(negedge clk);
            rst_n = 1'b1;
            m_pc = '0; m_icount = 0; m_ccount = 0;
            @(negedge clk);
            check("midmem_idle_after", 64'(strobes()), 64'd0);
        end

        // Free-run 260 back-to-back nops: both counters saturate.
        do_reset(1'b0);
        begin
            int retired = 0;
            bus.icode_in = 4'h1;
            bus.next_pc_in = 64'h77;
            bus.run = 1'b1;
            for (int c = 0; c < 3000 && retired < 260; c++) begin
                @(negedge clk);
                if (bus.pc_en) retired++;
                if (retired == 260) bus.run = 1'b0;
            end
            @(negedge clk);
            check("sat_retired", 64'(retired), 64'd260);
            check("sat_idle", 64'(strobes()), 64'd0);
            check("sat_icount", 64'(bus.instr_count), 64'(CntMax));
            check("sat_ccount", 64'(bus.cycle_count), 64'(CntMax));
            check("sat_pc", bus.pc, 64'h77);
            m_pc = 64'h77; m_icount = CntMax; m_ccount = CntMax;
        end

        // Random instructions against the model.
        do_reset(1'b0);
        for (int i = 0; i < 150; i++) begin
            vec_t v;
            v.icode  = 4'($urandom);
            v.valid  = ($urandom_range(0, 9) != 0);
            v.ierr   = ($urandom_range(0, 19) == 0);
            v.ack_at = $urandom_range(0, 6);
            v.derr   = ($urandom_range(0, 7) == 0);
            v.npc    = {$urandom, $urandom};
            v = predict(v);
            run_instr(v, $sformatf("rnd%0d", i));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
